// File: rtl/tile_map_pkg.sv
// Shared tile-map definitions for the map writer and the VGA renderer.
// Pure definitions: no latency, no flow control.
package tile_map_pkg;

    localparam int MAP_W         = 20;
    localparam int MAP_H         = 15;
    localparam int BYTES_PER_ROW = 10;

    localparam logic [3:0] TILE_WALL   = 4'h0;
    localparam logic [3:0] TILE_FLOOR  = 4'h1;
    localparam logic [3:0] TILE_PLAYER = 4'h2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_DST,
        ST_CHK_DST,
        ST_WR_DST,
        ST_RD_SRC,
        ST_WR_SRC,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    // y*10 + x/2 built from shifts: y*8 + y*2.
    function automatic logic [11:0] tile_addr(input logic [4:0] x, input logic [3:0] y);
        return {5'd0, y, 3'd0} + {7'd0, y, 1'b0} + {8'd0, x[4:1]};
    endfunction

    function automatic logic [7:0] put_nibble(input logic [7:0] b, input logic odd,
                                              input logic [3:0] tile);
        return odd ? {tile, b[3:0]} : {b[7:4], tile};
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Switch debouncer: output follows the input after it differs for CYCLES consecutive cycles.
// Latency CYCLES cycles; a bounce back to the stable level restarts the count. No backpressure.
module switch_debounce #(
    parameter int CYCLES = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch
);

    localparam int            CW   = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] r_Count;
    logic          r_State;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Count <= '0;
            r_State <= 1'b0;
        end else if (i_Switch == r_State) begin
            r_Count <= '0;
        end else if (r_Count == LAST) begin
            r_State <= i_Switch;
            r_Count <= '0;
        end else begin
            r_Count <= r_Count + CW'(1);
        end
    end

    assign o_Switch = r_State;

endmodule

// File: rtl/tile_map_writer.sv
// Turns debounced switch presses into collision-checked player moves via BRAM read-modify-write.
// Move takes 6 busy cycles (2 when blocked); requests arriving while busy are dropped, not queued.
module tile_map_writer
    import tile_map_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int START_X         = 10,
    parameter int START_Y         = 7
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Switch_1,
    input  logic        i_Switch_2,
    input  logic        i_Switch_3,
    input  logic        i_Switch_4,
    output logic [11:0] o_Bram_Addr,
    output logic [7:0]  o_Bram_Wdata,
    output logic        o_Bram_We,
    input  logic [7:0]  i_Bram_Rdata,
    output logic [4:0]  o_Player_X,
    output logic [3:0]  o_Player_Y,
    output logic [6:0]  o_Moves,
    output logic        o_Busy
);

    logic [3:0] w_Raw;
    logic [3:0] w_Deb;
    logic [3:0] r_Deb_Prev;
    logic [3:0] w_Rise;

    state_t      r_State, w_Next;
    logic [11:0] r_Addr;
    logic [4:0]  r_Player_X, r_Dst_X, w_Dst_X;
    logic [3:0]  r_Player_Y, r_Dst_Y, w_Dst_Y;
    logic [6:0]  r_Moves;
    logic [7:0]  r_Dst_Byte;
    logic        w_Req_Vld;
    logic        w_In_Bounds;
    dir_t        w_Dir;
    logic [3:0]  w_Dst_Nibble;

    assign w_Raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    for (genvar g = 0; g < 4; g++) begin : g_deb
        switch_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .i_Clk    (i_Clk),
            .i_Rst    (i_Rst),
            .i_Switch (w_Raw[g]),
            .o_Switch (w_Deb[g])
        );
    end

    assign w_Rise = w_Deb & ~r_Deb_Prev;

    // Priority Up > Down > Left > Right, then bounds check against the current position.
    always_comb begin
        w_Req_Vld   = |w_Rise;
        w_Dir       = DIR_UP;
        w_Dst_X     = r_Player_X;
        w_Dst_Y     = r_Player_Y;
        w_In_Bounds = 1'b0;
        if (w_Rise[0])      w_Dir = DIR_UP;
        else if (w_Rise[1]) w_Dir = DIR_DOWN;
        else if (w_Rise[2]) w_Dir = DIR_LEFT;
        else                w_Dir = DIR_RIGHT;
        case (w_Dir)
            DIR_UP: begin
                w_In_Bounds = (r_Player_Y != 4'd0);
                w_Dst_Y     = r_Player_Y - 4'd1;
            end
            DIR_DOWN: begin
                w_In_Bounds = (r_Player_Y != 4'(MAP_H - 1));
                w_Dst_Y     = r_Player_Y + 4'd1;
            end
            DIR_LEFT: begin
                w_In_Bounds = (r_Player_X != 5'd0);
                w_Dst_X     = r_Player_X - 5'd1;
            end
            default: begin
                w_In_Bounds = (r_Player_X != 5'(MAP_W - 1));
                w_Dst_X     = r_Player_X + 5'd1;
            end
        endcase
    end

    assign w_Dst_Nibble = r_Dst_X[0] ? i_Bram_Rdata[7:4] : i_Bram_Rdata[3:0];

    always_comb begin
        w_Next       = r_State;
        o_Bram_We    = 1'b0;
        o_Bram_Wdata = 8'd0;
        case (r_State)
            ST_IDLE:    if (w_Req_Vld && w_In_Bounds) w_Next = ST_RD_DST;
            ST_RD_DST:  w_Next = ST_CHK_DST;
            ST_CHK_DST: w_Next = (w_Dst_Nibble == TILE_FLOOR) ? ST_WR_DST : ST_IDLE;
            ST_WR_DST: begin
                o_Bram_We    = 1'b1;
                o_Bram_Wdata = put_nibble(r_Dst_Byte, r_Dst_X[0], TILE_PLAYER);
                w_Next       = ST_RD_SRC;
            end
            ST_RD_SRC:  w_Next = ST_WR_SRC;
            // Source byte is re-read after the destination write so same-byte moves merge correctly.
            ST_WR_SRC: begin
                o_Bram_We    = 1'b1;
                o_Bram_Wdata = put_nibble(i_Bram_Rdata, r_Player_X[0], TILE_FLOOR);
                w_Next       = ST_DONE;
            end
            ST_DONE:    w_Next = ST_IDLE;
            default:    w_Next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State <= ST_IDLE;
        end else begin
            r_State <= w_Next;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Deb_Prev <= 4'd0;
            r_Addr     <= 12'd0;
            r_Dst_X    <= 5'd0;
            r_Dst_Y    <= 4'd0;
            r_Dst_Byte <= 8'd0;
            r_Player_X <= 5'(START_X);
            r_Player_Y <= 4'(START_Y);
            r_Moves    <= 7'd0;
        end else begin
            r_Deb_Prev <= w_Deb;
            case (r_State)
                ST_IDLE: begin
                    if (w_Req_Vld && w_In_Bounds) begin
                        r_Addr  <= tile_addr(w_Dst_X, w_Dst_Y);
                        r_Dst_X <= w_Dst_X;
                        r_Dst_Y <= w_Dst_Y;
                    end
                end
                ST_CHK_DST: r_Dst_Byte <= i_Bram_Rdata;
                ST_WR_DST:  r_Addr     <= tile_addr(r_Player_X, r_Player_Y);
                ST_DONE: begin
                    r_Player_X <= r_Dst_X;
                    r_Player_Y <= r_Dst_Y;
                    r_Moves    <= (r_Moves == 7'd99) ? 7'd0 : r_Moves + 7'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_Bram_Addr = r_Addr;
    assign o_Player_X  = r_Player_X;
    assign o_Player_Y  = r_Player_Y;
    assign o_Moves     = r_Moves;
    assign o_Busy      = (r_State != ST_IDLE);

endmodule

// File: tb/tb_tile_map_writer.sv
// Directed bench for tile_map_writer with a registered-read BRAM model and short debounce.
module tb_tile_map_writer;

    localparam int LOG = 24;

    logic        clk;
    logic        rst;
    logic [3:0]  sw;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  rdata;
    logic [4:0]  px;
    logic [3:0]  py;
    logic [6:0]  moves;
    logic        busy;

    logic [7:0]  mem [0:4095];
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [7:0]  ld_dat;

    int checks;
    int errors;

    logic [11:0] addr_log  [LOG];
    logic [7:0]  wdata_log [LOG];
    logic        we_log    [LOG];
    logic        busy_log  [LOG];
    logic [4:0]  x_log     [LOG];
    logic [6:0]  moves_log [LOG];

    tile_map_writer #(.DEBOUNCE_CYCLES(4), .START_X(10), .START_Y(7)) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Switch_1   (sw[0]),
        .i_Switch_2   (sw[1]),
        .i_Switch_3   (sw[2]),
        .i_Switch_4   (sw[3]),
        .o_Bram_Addr  (addr),
        .o_Bram_Wdata (wdata),
        .o_Bram_We    (we),
        .i_Bram_Rdata (rdata),
        .o_Player_X   (px),
        .o_Player_Y   (py),
        .o_Moves      (moves),
        .o_Busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_dat;
        else if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

    task automatic load(input logic [11:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_dat = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // All floor, player at (10,7) in the low nibble of byte 75.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; sw = 4'd0;
        for (int i = 0; i < 150; i++) load(12'(i), (i == 75) ? 8'h12 : 8'h11);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // sw_a applied first, sw_b one cycle later; outputs logged each negedge, then switches released.
    task automatic run_press(input logic [3:0] sw_a, input logic [3:0] sw_b);
        @(negedge clk);
        sw = sw_a;
        for (int i = 0; i < LOG; i++) begin
            @(negedge clk);
            addr_log[i] = addr; wdata_log[i] = wdata; we_log[i] = we;
            busy_log[i] = busy; x_log[i] = px; moves_log[i] = moves;
            if (i == 0) sw = sw_b;
        end
        sw = 4'd0;
        repeat (12) @(negedge clk);
    endtask

    function automatic int first_busy();
        for (int i = 0; i < LOG; i++) if (busy_log[i]) return i;
        return -1;
    endfunction

    function automatic int busy_count();
        int n = 0;
        for (int i = 0; i < LOG; i++) if (busy_log[i]) n++;
        return n;
    endfunction

    function automatic int we_count();
        int n = 0;
        for (int i = 0; i < LOG; i++) if (we_log[i]) n++;
        return n;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (addr !== 12'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr); end
        checks++; if (wdata !== 8'd0) begin errors++; $display("FAIL reset_wdata: got %h want 00", wdata); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", we); end
        checks++; if (px !== 5'd10) begin errors++; $display("FAIL reset_x: got %0d want 10", px); end
        checks++; if (py !== 4'd7) begin errors++; $display("FAIL reset_y: got %0d want 7", py); end
        checks++; if (moves !== 7'd0) begin errors++; $display("FAIL reset_moves: got %0d want 0", moves); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_clear_move();
        int t0;
        do_reset();
        run_press(4'b1000, 4'b1000);
        t0 = first_busy();
        checks++; if (t0 != 4) begin errors++; $display("FAIL clear_accept_cycle: got %0d want 4", t0); end
        if (t0 < 0) t0 = 0;
        if (t0 > LOG - 7) t0 = LOG - 7;
        checks++; if (addr_log[t0] !== 12'd75) begin errors++; $display("FAIL clear_rd_addr: got %0d want 75", addr_log[t0]); end
        checks++; if (we_log[t0+2] !== 1'b1 || addr_log[t0+2] !== 12'd75 || wdata_log[t0+2] !== 8'h22) begin
            errors++; $display("FAIL clear_dst_write: got we=%b addr=%0d data=%h want we=1 addr=75 data=22",
                               we_log[t0+2], addr_log[t0+2], wdata_log[t0+2]); end
        checks++; if (we_log[t0+4] !== 1'b1 || addr_log[t0+4] !== 12'd75 || wdata_log[t0+4] !== 8'h21) begin
            errors++; $display("FAIL clear_src_write: got we=%b addr=%0d data=%h want we=1 addr=75 data=21",
                               we_log[t0+4], addr_log[t0+4], wdata_log[t0+4]); end
        checks++; if (we_count() != 2) begin errors++; $display("FAIL clear_we_pulses: got %0d want 2", we_count()); end
        checks++; if (busy_count() != 6) begin errors++; $display("FAIL clear_busy_len: got %0d want 6", busy_count()); end
        checks++; if (x_log[t0+5] !== 5'd10 || x_log[t0+6] !== 5'd11) begin
            errors++; $display("FAIL clear_x_timing: got %0d,%0d want 10,11", x_log[t0+5], x_log[t0+6]); end
        checks++; if (moves_log[t0+6] !== 7'd1) begin errors++; $display("FAIL clear_moves: got %0d want 1", moves_log[t0+6]); end
        checks++; if (mem[75] !== 8'h21) begin errors++; $display("FAIL clear_mem75: got %h want 21", mem[75]); end
    endtask

    task automatic test_blocked();
        int t0;
        do_reset();
        load(12'd65, 8'h10);
        run_press(4'b0001, 4'b0001);
        t0 = first_busy();
        if (t0 < 0) t0 = 0;
        checks++; if (addr_log[t0] !== 12'd65) begin errors++; $display("FAIL blocked_rd_addr: got %0d want 65", addr_log[t0]); end
        checks++; if (we_count() != 0) begin errors++; $display("FAIL blocked_we: got %0d pulses want 0", we_count()); end
        checks++; if (busy_count() != 2) begin errors++; $display("FAIL blocked_busy_len: got %0d want 2", busy_count()); end
        checks++; if (px !== 5'd10 || py !== 4'd7 || moves !== 7'd0) begin
            errors++; $display("FAIL blocked_state: got x=%0d y=%0d moves=%0d want 10 7 0", px, py, moves); end
        checks++; if (mem[65] !== 8'h10) begin errors++; $display("FAIL blocked_mem65: got %h want 10", mem[65]); end
    endtask

    task automatic test_edge_of_map();
        int bad;
        do_reset();
        for (int m = 0; m < 10; m++) run_press(4'b0100, 4'b0100);
        checks++; if (px !== 5'd0 || moves !== 7'd10) begin
            errors++; $display("FAIL edge_walk: got x=%0d moves=%0d want 0 10", px, moves); end
        checks++; if (mem[70] !== 8'h12) begin errors++; $display("FAIL edge_mem70: got %h want 12", mem[70]); end
        run_press(4'b0100, 4'b0100);
        bad = 0;
        for (int i = 0; i < LOG; i++) if (addr_log[i] !== 12'd70) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL edge_addr_hold: got %0d cycles off 70 want 0", bad); end
        checks++; if (we_count() != 0) begin errors++; $display("FAIL edge_we: got %0d pulses want 0", we_count()); end
        checks++; if (busy_count() != 0) begin errors++; $display("FAIL edge_busy: got %0d cycles want 0", busy_count()); end
        checks++; if (px !== 5'd0 || moves !== 7'd10) begin
            errors++; $display("FAIL edge_state: got x=%0d moves=%0d want 0 10", px, moves); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        run_press(4'b1001, 4'b1011);
        checks++; if (px !== 5'd10 || py !== 4'd6) begin
            errors++; $display("FAIL simul_pos: got x=%0d y=%0d want 10 6", px, py); end
        checks++; if (moves !== 7'd1) begin errors++; $display("FAIL simul_moves: got %0d want 1", moves); end
        checks++; if (busy_count() != 6 || we_count() != 2) begin
            errors++; $display("FAIL simul_one_move: got busy=%0d we=%0d want 6 2", busy_count(), we_count()); end
        checks++; if (mem[65] !== 8'h12 || mem[75] !== 8'h11) begin
            errors++; $display("FAIL simul_mem: got m65=%h m75=%h want 12 11", mem[65], mem[75]); end
    endtask

    task automatic test_bounce_and_wrap();
        int seen;
        do_reset();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i % 2 == 0) sw[0] = ~sw[0];
            if (busy) seen++;
        end
        sw = 4'd0;
        repeat (12) @(negedge clk);
        checks++; if (seen != 0 || moves !== 7'd0 || py !== 4'd7) begin
            errors++; $display("FAIL bounce: got busy=%0d moves=%0d y=%0d want 0 0 7", seen, moves, py); end
        for (int m = 1; m <= 100; m++) begin
            run_press((m % 2 == 1) ? 4'b1000 : 4'b0100, (m % 2 == 1) ? 4'b1000 : 4'b0100);
            if (m == 99) begin
                checks++; if (moves !== 7'd99 || px !== 5'd11) begin
                    errors++; $display("FAIL wrap_99: got moves=%0d x=%0d want 99 11", moves, px); end
            end
        end
        checks++; if (moves !== 7'd0) begin errors++; $display("FAIL wrap_0: got %0d want 0", moves); end
        checks++; if (px !== 5'd10 || mem[75] !== 8'h12) begin
            errors++; $display("FAIL wrap_samebyte: got x=%0d m75=%h want 10 12", px, mem[75]); end
    endtask

    task automatic test_reset_mid_move();
        int t;
        int nwe;
        int nbusy;
        do_reset();
        @(negedge clk);
        sw = 4'b1000;
        t = 0;
        while (busy !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_start: busy=%b after %0d cycles want 1", busy, t); end
        repeat (3) @(negedge clk);
        checks++; if (addr !== 12'd75 || we !== 1'b0) begin
            errors++; $display("FAIL midrst_rd_src: got addr=%0d we=%b want 75 0", addr, we); end
        #1 rst = 1'b1; sw = 4'd0;
        #1;
        checks++; if (addr !== 12'd0 || wdata !== 8'd0 || we !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got addr=%0d data=%h we=%b busy=%b want 0 00 0 0", addr, wdata, we, busy); end
        checks++; if (px !== 5'd10 || py !== 4'd7 || moves !== 7'd0) begin
            errors++; $display("FAIL midrst_pos: got x=%0d y=%0d moves=%0d want 10 7 0", px, py, moves); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        nwe = 0; nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (we) nwe++;
            if (busy) nbusy++;
        end
        checks++; if (nwe != 0 || nbusy != 0) begin
            errors++; $display("FAIL midrst_after: got we=%0d busy=%0d want 0 0", nwe, nbusy); end
        checks++; if (mem[75] !== 8'h22) begin errors++; $display("FAIL midrst_mem75: got %h want 22", mem[75]); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; sw = 4'd0;
        ld_en = 1'b0; ld_addr = 12'd0; ld_dat = 8'd0;
        test_reset();
        test_clear_move();
        test_blocked();
        test_edge_of_map();
        test_simultaneous();
        test_bounce_and_wrap();
        test_reset_mid_move();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_map_writer.md
# tile_map_writer

Write side of the tile-map BRAM that the VGA renderer reads. The block debounces the four board switches and turns each accepted press into one player step. Each step is a collision-checked read-modify-write of 4-bit tile nibbles through the shared BRAM port. It also tracks the player position and a 0–99 move count for the 7-segment display.

## Interface
- `DEBOUNCE_CYCLES`, 250000 — cycles a switch level must stay stable before it is accepted (10 ms at 25 MHz).
- `START_X`, 10 — player column after reset (0–19).
- `START_Y`, 7 — player row after reset (0–14).
- `i_Clk` in 1 — system clock, 25 MHz.
- `i_Rst` in 1 — asynchronous, active-high reset.
- `i_Switch_1` in 1 — Up, raw level.
- `i_Switch_2` in 1 — Down, raw level.
- `i_Switch_3` in 1 — Left, raw level.
- `i_Switch_4` in 1 — Right, raw level.
- `o_Bram_Addr` out 12 — byte address; drives both RADDR and WADDR.
- `o_Bram_Wdata` out 8 — write byte.
- `o_Bram_We` out 1 — write enable, one-cycle pulse.
- `i_Bram_Rdata` in 8 — BRAM RDATA; 1-cycle registered read latency.
- `o_Player_X` out 5 — current player column.
- `o_Player_Y` out 4 — current player row.
- `o_Moves` out 7 — completed-move counter, 0–99.
- `o_Busy` out 1 — high while a move is in flight.

## Operation
- **Map layout:** 20×15 tiles, 4 bits per tile, 10 bytes per row.
  - Address = y*10 + x/2.
  - Even x uses bits [3:0]; odd x uses bits [7:4].
- **Tile codes:** 4'h0 wall, 4'h1 floor, 4'h2 player. Only floor is enterable.
- **Switch handling:** each switch passes through a debouncer. A rising edge of the debounced level is a request.
  - Simultaneous requests resolve by priority: Up > Down > Left > Right.
  - Requests arriving while `o_Busy`=1 are dropped, not queued.
- **Bounds check:** done in IDLE before any BRAM access. Up at y=0, Down at y=14, Left at x=0 and Right at x=19 are discarded with no BRAM cycle.
- **FSM states:** IDLE → RD_DST → CHK_DST → WR_DST → RD_SRC → WR_SRC → DONE → IDLE.
  - RD_DST: drive the destination address.
  - CHK_DST: latch `i_Bram_Rdata`. If the destination nibble ≠ floor, go to IDLE (blocked, no count).
  - WR_DST: write the latched byte with the destination nibble replaced by player. `o_Bram_We`=1.
  - RD_SRC: drive the source address.
  - WR_SRC: write `i_Bram_Rdata` with the source nibble replaced by floor. `o_Bram_We`=1.
  - DONE: update X/Y to the destination; increment `o_Moves`, wrapping 99→0.
- **Same-byte moves** (e.g. x 10↔11): the source is re-read after the destination write, so the second write merges onto fresh data and both nibbles end correct.
- **Idle outputs:** `o_Bram_Addr` holds the last value; `o_Bram_We`=0.

## Timing
- **Reset values:**
  - `o_Bram_Addr`=0, `o_Bram_Wdata`=0, `o_Bram_We`=0.
  - `o_Player_X`=START_X, `o_Player_Y`=START_Y.
  - `o_Moves`=0, `o_Busy`=0, FSM=IDLE, debouncers cleared to 0.
- **Request timing:** a request is accepted in the cycle after the debounced edge; call that cycle 0 (IDLE→RD_DST).
- **Move latency:**
  - Destination write at cycle 2.
  - Source write at cycle 4.
  - Position and count visible at cycle 6.
  - `o_Busy` high for cycles 0–5 (6 cycles).
- **Blocked move:** returns to IDLE after cycle 1 with `o_Busy` high for 2 cycles and no write.
- **Reset mid-move:** aborts immediately. BRAM is not restored; a reset between WR_DST and WR_SRC can leave two player tiles. This is accepted; the map is reloaded only by reconfiguration.
- **Debounce:** a level change must hold for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts that switch's counter.

## Structure
- **Shared package `tile_map_pkg`:**
  - MAP_W=20, MAP_H=15, BYTES_PER_ROW=10.
  - TILE_WALL, TILE_FLOOR, TILE_PLAYER.
  - FSM state encodings.
  - Direction codes.
- The VGA renderer imports the same package.
- **Sub-module `switch_debounce`:** one instance per switch, with a counter and stable-level register. Edge detection stays in `tile_map_writer`.

## Test plan
- **Clear move:** Right press from (10,7) with floor at (11,7) → cycle 2 writes byte 75 with [7:4]=2; cycle 4 writes byte 75 with [3:0]=1; X=11, `o_Moves`=1.
- **Blocked move:** Up with wall at (10,6) → byte 65 read, no `o_Bram_We` pulse, position and count unchanged, `o_Busy` high exactly 2 cycles.
- **Edge of map:** player at (0,7), Left press → no BRAM address change, no write, `o_Busy` stays 0.
- **Simultaneous press:** Up and Right debounced edges in the same cycle → only Up executes. A Down press during `o_Busy` is dropped.
- **Bounce and wrap:** with DEBOUNCE_CYCLES=4, a switch toggled every 2 cycles → no request. Then 100 valid moves → `o_Moves` wraps 99→0.
- **Reset mid-move:** `i_Rst` asserted asynchronously in RD_SRC → outputs immediately at reset values, no further `o_Bram_We`, FSM=IDLE after release.
